multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before a bus error.
  TW, 4, timeout counter width; MEM_TIMEOUT SHALL be at most 2^TW-1.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state changes on rising edge.
  rst_n  in  1  asynchronous active-low reset.
  imem_rdata_op  in  7  opcode field of the fetched instruction word.
  imem_ready  in  1  instruction memory completes the read this cycle.
  dmem_ready  in  1  data memory completes the access this cycle.
  zero  in  1  ALU zero flag, valid in EXEC.
  imem_req  out  1  instruction fetch request.
  dmem_req  out  1  data access request.
  ir_write, pc_write  out  1 each  latch the instruction register / update the PC.
  pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
  reg_write, mem_read, mem_write, alusrc, mem_to_reg, branch  out  1 each  datapath controls.
  alu_op  out  2  ALU class: 00 add, 01 subtract/compare, 10 funct-decoded.
  instr_done  out  1  one-cycle pulse when an instruction retires.
  illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
  bus_error  out  1  sticky error flag; set on memory timeout.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-004 States: FETCH, DECODE, EXEC, MEM, WB, HALT, held in a registered state variable.
REQ-005 Outputs SHALL decode combinationally from the current state, the latched opcode, imem_ready/dmem_ready and zero; any output not listed for a state SHALL be 0.
REQ-006 FETCH: imem_req=1. When imem_ready=1: ir_write=1, pc_write=1, pc_src=0, imem_rdata_op latched into the internal opcode register, next state DECODE. Otherwise the block SHALL stay in FETCH.
REQ-007 DECODE lasts one cycle.
  Supported opcodes: 0110011 R, 0000011 load, 0010011 ALU-immediate, 0100011 store, 1100011 branch.
  Supported opcode: next state EXEC.
  Any other opcode: illegal_op=1 for that cycle, next state FETCH, no register or memory write.
REQ-008 EXEC lasts one cycle, with outputs by class:
  R: alusrc=0, alu_op=10; next WB.
  ALU-immediate: alusrc=1, alu_op=00; next WB.
  load/store: alusrc=1, alu_op=00; next MEM.
  branch: alusrc=0, alu_op=01, branch=1, pc_write=zero, pc_src=1, instr_done=1; next FETCH.
REQ-009 MEM: dmem_req=1, alusrc=1, alu_op=00; mem_read=1 for load, mem_write=1 for store; these outputs SHALL stay asserted until dmem_ready=1.
  On dmem_ready with a load: next state WB.
  On dmem_ready with a store: instr_done=1, next state FETCH.
REQ-010 WB lasts one cycle: reg_write=1, mem_to_reg=1 for load and 0 otherwise, instr_done=1; next state FETCH.
REQ-011 Latency with zero-wait memory (imem_ready/dmem_ready high on first request cycle):
  R and ALU-immediate: 4 cycles.
  load: 5 cycles.
  store: 4 cycles.
  branch: 3 cycles.
  Each memory wait cycle SHALL add exactly one cycle.
REQ-012 Wait counter:
  Counts cycles spent in FETCH or MEM without the matching ready.
  Clears on state exit.
  Saturates, with no wrap-around.
REQ-013 Timeout: if the counter reaches MEM_TIMEOUT while ready is still low, the next state SHALL be HALT and bus_error SHALL be set.
REQ-014 Ready arriving on the same cycle the counter reaches MEM_TIMEOUT SHALL win: normal completion, no error.
REQ-015 HALT: all strobes 0, bus_error=1. Only reset SHALL leave HALT.
REQ-016 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-017 reg_write and mem_write SHALL never both be 1 in the same cycle.
REQ-018 mem_read and mem_write SHALL never both be 1 in the same cycle.

Reset
REQ-019 While rst_n=0, regardless of clk:
  state=FETCH, opcode register=0000000, wait counter=0, bus_error=0;
  all strobes 0 except imem_req, which follows FETCH decoding once rst_n=1.
REQ-020 Reset asserted mid-instruction (including during MEM with mem_write=1) SHALL deassert every strobe immediately, with no completion pulse.
REQ-021 After rst_n rises, the first fetch request SHALL appear at the first rising edge, in state FETCH.

Verification
REQ-022 R-type 0110011, ready always 1 -> state sequence FETCH, DECODE, EXEC(alu_op=10), WB(reg_write=1); instr_done on cycle 4.
REQ-023 Load 0000011, dmem_ready delayed 3 cycles -> mem_read=1 and dmem_req=1 for 4 cycles; WB with mem_to_reg=1; total 8 cycles.
REQ-024 Branch 1100011, zero=1 -> EXEC shows pc_write=1 and pc_src=1; with zero=0 -> pc_write=0; both retire in 3 cycles.
REQ-025 Opcode 1111111 -> illegal_op pulses in DECODE; next cycle FETCH; no reg_write or mem_write at any point.
REQ-026 imem_ready held 0, MEM_TIMEOUT=15 -> HALT with bus_error=1 after 15 wait cycles; later imem_ready=1 is ignored until rst_n pulses low.
REQ-027 Store 0100011 with rst_n dropped during MEM -> mem_write falls asynchronously; after release, state is FETCH and bus_error=0.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Handshake/control bundle between the multi-cycle controller and its datapath/memories.
// The controller uses the slave view; the datapath side uses the master view.
interface multi_cycle_ctrl_if;
  logic [6:0] imem_rdata_op;
  logic       imem_ready;
  logic       dmem_ready;
  logic       zero;
  logic       imem_req;
  logic       dmem_req;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       alusrc;
  logic       mem_to_reg;
  logic       branch;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_error;

  modport slave (
    input  imem_rdata_op, imem_ready, dmem_ready, zero,
    output imem_req, dmem_req, ir_write, pc_write, pc_src, reg_write, mem_read,
           mem_write, alusrc, mem_to_reg, branch, alu_op, instr_done, illegal_op, bus_error
  );

  modport master (
    output imem_rdata_op, imem_ready, dmem_ready, zero,
    input  imem_req, dmem_req, ir_write, pc_write, pc_src, reg_write, mem_read,
           mem_write, alusrc, mem_to_reg, branch, alu_op, instr_done, illegal_op, bus_error
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC-V style control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeout into a sticky HALT state. Strobes decode combinationally from the current state.
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input logic               clk,
  input logic               rst_n,
  multi_cycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [TW-1:0] CNT_ZERO  = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE   = TW'(32'd1);
  localparam logic [TW-1:0] CNT_MAX   = {TW{1'b1}};
  localparam logic [TW-1:0] LAST_WAIT = TW'(MEM_TIMEOUT - 32'd1);

  state_e        state_q, state_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          bus_error_q, bus_error_d;

  logic [TW-1:0] cnt_next_s;
  logic          wait_expired_s;
  logic          is_load_s;
  logic          is_store_s;

  logic          imem_req_s, dmem_req_s, ir_write_s, pc_write_s, pc_src_s;
  logic          reg_write_s, mem_read_s, mem_write_s, alusrc_s, mem_to_reg_s;
  logic          branch_s, instr_done_s, illegal_op_s;
  logic [1:0]    alu_op_s;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  // Next-state, wait-counter and strobe decode.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    cnt_d        = cnt_q;
    bus_error_d  = bus_error_q;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    alusrc_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    branch_s     = 1'b0;
    alu_op_s     = 2'b00;
    instr_done_s = 1'b0;
    illegal_op_s = 1'b0;

    // Saturating increment; the cycle whose wait brings the count to MEM_TIMEOUT
    // is the last one allowed, so ready on that cycle still completes normally.
    cnt_next_s     = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
    wait_expired_s = (cnt_q >= LAST_WAIT);
    is_load_s      = (opcode_q == OP_LOAD);
    is_store_s     = (opcode_q == OP_STORE);

    case (state_q)
      FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          opcode_d   = bus.imem_rdata_op;
          cnt_d      = CNT_ZERO;
          state_d    = DECODE;
        end else if (wait_expired_s) begin
          cnt_d       = CNT_ZERO;
          bus_error_d = 1'b1;
          state_d     = HALT;
        end else begin
          cnt_d = cnt_next_s;
        end
      end
      DECODE: begin
        if (is_legal(opcode_q)) begin
          state_d = EXEC;
        end else begin
          illegal_op_s = 1'b1;
          state_d      = FETCH;
        end
      end
      EXEC: begin
        case (opcode_q)
          OP_R: begin
            alu_op_s = 2'b10;
            state_d  = WB;
          end
          OP_IMM: begin
            alusrc_s = 1'b1;
            state_d  = WB;
          end
          OP_LOAD, OP_STORE: begin
            alusrc_s = 1'b1;
            state_d  = MEM;
          end
          OP_BRANCH: begin
            alu_op_s     = 2'b01;
            branch_s     = 1'b1;
            pc_write_s   = bus.zero;
            pc_src_s     = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        dmem_req_s  = 1'b1;
        alusrc_s    = 1'b1;
        mem_read_s  = is_load_s;
        mem_write_s = is_store_s;
        if (bus.dmem_ready) begin
          cnt_d = CNT_ZERO;
          if (is_load_s) begin
            state_d = WB;
          end else begin
            instr_done_s = 1'b1;
            state_d      = FETCH;
          end
        end else if (wait_expired_s) begin
          cnt_d       = CNT_ZERO;
          bus_error_d = 1'b1;
          state_d     = HALT;
        end else begin
          cnt_d = cnt_next_s;
        end
      end
      WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = is_load_s;
        instr_done_s = 1'b1;
        state_d      = FETCH;
      end
      HALT: begin
        bus_error_d = 1'b1;
        state_d     = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // State, opcode, wait counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      opcode_q    <= 7'b0000000;
      cnt_q       <= CNT_ZERO;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Gating with rst_n drops every strobe the instant reset asserts, even mid-access.
  assign bus.imem_req   = rst_n & imem_req_s;
  assign bus.dmem_req   = rst_n & dmem_req_s;
  assign bus.ir_write   = rst_n & ir_write_s;
  assign bus.pc_write   = rst_n & pc_write_s;
  assign bus.pc_src     = rst_n & pc_src_s;
  assign bus.reg_write  = rst_n & reg_write_s;
  assign bus.mem_read   = rst_n & mem_read_s;
  assign bus.mem_write  = rst_n & mem_write_s;
  assign bus.alusrc     = rst_n & alusrc_s;
  assign bus.mem_to_reg = rst_n & mem_to_reg_s;
  assign bus.branch     = rst_n & branch_s;
  assign bus.alu_op     = rst_n ? alu_op_s : 2'b00;
  assign bus.instr_done = rst_n & instr_done_s;
  assign bus.illegal_op = rst_n & illegal_op_s;
  assign bus.bus_error  = bus_error_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expected strobe vectors are queued
// when an instruction is scheduled and checked one per clock as the DUT steps.
module tb_multi_cycle_ctrl;

  localparam int T = 15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Bit masks of the observed vector
  localparam logic [15:0] V_IMEM    = 16'h8000;
  localparam logic [15:0] V_DMEM    = 16'h4000;
  localparam logic [15:0] V_IRW     = 16'h2000;
  localparam logic [15:0] V_PCW     = 16'h1000;
  localparam logic [15:0] V_PCSRC   = 16'h0800;
  localparam logic [15:0] V_REGW    = 16'h0400;
  localparam logic [15:0] V_MRD     = 16'h0200;
  localparam logic [15:0] V_MWR     = 16'h0100;
  localparam logic [15:0] V_ASRC    = 16'h0080;
  localparam logic [15:0] V_M2R     = 16'h0040;
  localparam logic [15:0] V_BR      = 16'h0020;
  localparam logic [15:0] V_ALU_F   = 16'h0010;
  localparam logic [15:0] V_ALU_SUB = 16'h0008;
  localparam logic [15:0] V_DONE    = 16'h0004;
  localparam logic [15:0] V_ILL     = 16'h0002;
  localparam logic [15:0] V_BERR    = 16'h0001;

  localparam int C_FW = 0, C_F = 1, C_D = 2, C_E = 3, C_MW = 4, C_M = 5, C_WB = 6, C_H = 7;

  typedef struct {
    int          code;
    int          n;
    logic        ir;
    logic        dr;
    logic        z;
    logic [6:0]  op;
    logic [15:0] exp;
  } cyc_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   instr_n;
  cyc_t sb[$];

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.MEM_TIMEOUT(T), .TW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] obs_v;
  assign obs_v = {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.reg_write, bus.mem_read, bus.mem_write, bus.alusrc, bus.mem_to_reg,
                  bus.branch, bus.alu_op, bus.instr_done, bus.illegal_op, bus.bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string cname(input int c);
    case (c)
      C_FW:    return "fetch_wait";
      C_F:     return "fetch";
      C_D:     return "decode";
      C_E:     return "exec";
      C_MW:    return "mem_wait";
      C_M:     return "mem";
      C_WB:    return "wb";
      C_H:     return "halt";
      default: return "other";
    endcase
  endfunction

  function automatic logic legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom_range(127, 0));
  endfunction

  function automatic void push(input int code, input logic ir, input logic dr,
                               input logic z, input logic [6:0] op, input logic [15:0] e);
    cyc_t c;
    c.code = code; c.n = instr_n; c.ir = ir; c.dr = dr; c.z = z; c.op = op; c.exp = e;
    sb.push_back(c);
  endfunction

  function automatic void push_halt();
    for (int i = 0; i < 4; i++) push(C_H, 1'b1, 1'b1, 1'b1, junk(), V_BERR);
  endfunction

  // Expected per-cycle behaviour of one instruction; cut>0 stops after cut MEM wait cycles.
  function automatic void push_instr(input logic [6:0] op, input int iw, input int dw,
                                     input logic z, input int cut);
    logic [15:0] mb;
    logic        ld;
    logic        st;
    instr_n++;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    for (int i = 0; i < iw && i < T; i++) push(C_FW, 1'b0, 1'b1, z, junk(), V_IMEM);
    if (iw >= T) begin
      push_halt();
      return;
    end
    push(C_F, 1'b1, 1'b1, z, op, V_IMEM | V_IRW | V_PCW);
    if (!legal(op)) begin
      push(C_D, 1'b1, 1'b1, z, junk(), V_ILL);
      return;
    end
    push(C_D, 1'b1, 1'b1, z, junk(), 16'h0000);
    case (op)
      OP_R:      push(C_E, 1'b1, 1'b1, z, junk(), V_ALU_F);
      OP_IMM:    push(C_E, 1'b1, 1'b1, z, junk(), V_ASRC);
      OP_BRANCH: push(C_E, 1'b1, 1'b1, z, junk(),
                      V_ALU_SUB | V_BR | V_PCSRC | V_DONE | (z ? V_PCW : 16'h0000));
      default:   push(C_E, 1'b1, 1'b1, z, junk(), V_ASRC);
    endcase
    if (op == OP_BRANCH) return;
    if (ld || st) begin
      mb = V_DMEM | V_ASRC | (ld ? V_MRD : V_MWR);
      if (cut > 0) begin
        for (int i = 0; i < cut; i++) push(C_MW, 1'b1, 1'b0, z, junk(), mb);
        return;
      end
      for (int i = 0; i < dw && i < T; i++) push(C_MW, 1'b1, 1'b0, z, junk(), mb);
      if (dw >= T) begin
        push_halt();
        return;
      end
      push(C_M, 1'b1, 1'b1, z, junk(), mb | (st ? V_DONE : 16'h0000));
      if (st) return;
    end
    push(C_WB, 1'b1, 1'b1, z, junk(), V_REGW | V_DONE | (ld ? V_M2R : 16'h0000));
  endfunction

  task automatic chk(input string tag, input int n, input logic [15:0] o, input logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s #%0d: observed=%h expected=%h", tag, n, o, e);
    end
  endtask

  task automatic drain();
    cyc_t c;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      bus.imem_ready    = c.ir;
      bus.dmem_ready    = c.dr;
      bus.zero          = c.z;
      bus.imem_rdata_op = c.op;
      @(negedge clk);
      chk(cname(c.code), c.n, obs_v, c.exp);
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset with readies high (must stay masked), release just after an edge.
  task automatic do_reset();
    rst_n             = 1'b0;
    bus.imem_ready    = 1'b1;
    bus.dmem_ready    = 1'b1;
    bus.zero          = 1'b1;
    bus.imem_rdata_op = OP_R;
    #1;
    chk("rst_async", instr_n, obs_v, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_hold", instr_n, obs_v, 16'h0000);
    @(posedge clk);
    #1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    rst_n          = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    instr_n = 0;
    do_reset();

    push_instr(OP_R, 0, 0, 1'b0, 0);
    push_instr(OP_IMM, 2, 0, 1'b1, 0);
    push_instr(OP_LOAD, 0, 3, 1'b0, 0);
    push_instr(OP_STORE, 0, 0, 1'b1, 0);
    push_instr(OP_BRANCH, 0, 0, 1'b1, 0);
    push_instr(OP_BRANCH, 1, 0, 1'b0, 0);
    push_instr(7'b1111111, 0, 0, 1'b0, 0);
    push_instr(OP_R, 0, 0, 1'b1, 0);
    push_instr(7'b1101111, 0, 0, 1'b0, 0);
    push_instr(OP_R, T - 1, 0, 1'b0, 0);
    push_instr(OP_LOAD, 0, T - 1, 1'b1, 0);
    push_instr(OP_STORE, 1, 2, 1'b0, 0);
    drain();

    // Reset dropped while a store is waiting in MEM
    push_instr(OP_STORE, 0, 0, 1'b0, 2);
    drain();
    bus.dmem_ready = 1'b0;
    #1;
    chk("mem_before_rst", instr_n, obs_v, V_DMEM | V_ASRC | V_MWR);
    rst_n = 1'b0;
    #1;
    chk("mem_async_rst", instr_n, obs_v, 16'h0000);
    do_reset();
    push_instr(OP_R, 0, 0, 1'b0, 0);
    drain();

    // Instruction fetch timeout, HALT ignores imem_ready until reset
    push_instr(OP_R, T, 0, 1'b0, 0);
    drain();
    do_reset();
    push_instr(OP_IMM, 0, 0, 1'b0, 0);
    drain();

    // Data memory timeout
    push_instr(OP_STORE, 0, T, 1'b0, 0);
    drain();
    do_reset();
    push_instr(OP_LOAD, 0, 0, 1'b1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
